// File: rtl/axi_mem_bridge_if.sv
// AXI channel bundle between the adapter stage and its downstream endpoints.
interface axi_channel #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_mem_bridge.sv
// AXI slave that serialises one burst at a time onto a single-port SRAM.
// Reads take two cycles per beat (request, then data); writes take one.
module axi_mem_bridge #(
  parameter int ID_WIDTH       = 4,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int USER_WIDTH     = 1,
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_channel.slave                 slave,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH/8-1:0]   mem_wmask,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);
  localparam int OFFS = $clog2(DATA_WIDTH/8);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR, WR_RESP} state_e;

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;   // 1: write wins a tie
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  hold_q;           // past the first RD_DATA cycle
  logic                  ar_rdy, aw_rdy, w_rdy;

  logic [ADDR_WIDTH-1:0] incr, wrap_mask, addr_nxt;
  logic                  last_beat;

  assign last_beat = (cnt_q == len_q);

  // Next beat address for the latched burst type (reserved type behaves as INCR)
  always_comb begin
    incr      = ADDR_WIDTH'(1) << size_q;
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
      default: addr_nxt = addr_q + incr;
    endcase
  end

  // Next-state, arbitration and memory strobes
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = err_q;
    ar_rdy  = 1'b0;
    aw_rdy  = 1'b0;
    w_rdy   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        // Readies are combinational here, so keep them quiet while reset is held.
        if (!rst) begin
          if (slave.ar_valid && (!slave.aw_valid || !prio_q)) begin
            ar_rdy  = 1'b1;
            prio_d  = 1'b1;
            id_d    = slave.ar_id;
            addr_d  = slave.ar_addr;
            len_d   = slave.ar_len;
            size_d  = slave.ar_size;
            burst_d = slave.ar_burst;
            cnt_d   = 8'd0;
            state_d = RD_REQ;
          end else if (slave.aw_valid) begin
            aw_rdy  = 1'b1;
            prio_d  = 1'b0;
            id_d    = slave.aw_id;
            addr_d  = slave.aw_addr;
            len_d   = slave.aw_len;
            size_d  = slave.aw_size;
            burst_d = slave.aw_burst;
            cnt_d   = 8'd0;
            state_d = WR;
          end
        end
      end
      RD_REQ: begin
        mem_req = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        if (slave.r_ready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            addr_d  = addr_nxt;
            state_d = RD_REQ;
          end
        end
      end
      WR: begin
        w_rdy = 1'b1;
        if (slave.w_valid) begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          if (slave.w_last != last_beat) err_d = 1'b1;
          cnt_d  = cnt_q + 8'd1;
          addr_d = addr_nxt;
          if (last_beat) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (slave.b_ready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and burst context registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
    end
  end

  // Capture the SRAM word on its single valid cycle so a stalled R beat stays stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      hold_q <= (state_q == RD_DATA);
      if (state_q == RD_DATA && !hold_q) rdata_q <= mem_rdata;
    end
  end

  assign mem_addr  = addr_q[OFFS +: MEM_ADDR_WIDTH];
  assign mem_wdata = slave.w_data;
  assign mem_wmask = mem_we ? slave.w_strb : '0;

  assign slave.ar_ready = ar_rdy;
  assign slave.aw_ready = aw_rdy;
  assign slave.w_ready  = w_rdy;

  // First data cycle forwards the SRAM output directly; later cycles replay the capture.
  assign slave.r_valid = (state_q == RD_DATA);
  assign slave.r_data  = hold_q ? rdata_q : mem_rdata;
  assign slave.r_id    = id_q;
  assign slave.r_resp  = 2'b00;
  assign slave.r_last  = last_beat;
  assign slave.r_user  = '0;

  assign slave.b_valid = (state_q == WR_RESP);
  assign slave.b_id    = id_q;
  assign slave.b_resp  = err_q ? 2'b10 : 2'b00;
  assign slave.b_user  = '0;

  // Sideband fields carry no meaning for a plain scratchpad.
  logic unused_sideband;
  assign unused_sideband = ^{slave.ar_lock, slave.ar_cache, slave.ar_prot, slave.ar_qos,
                             slave.ar_region, slave.ar_user, slave.aw_lock, slave.aw_cache,
                             slave.aw_prot, slave.aw_qos, slave.aw_region, slave.aw_user,
                             slave.w_user};
endmodule
